// File: rtl/framebuffer_flip_pkg.sv
// Shared constants for the framebuffer flip controller: register map,
// control/status bit positions and the flip FSM state type.
package framebuffer_flip_pkg;

  localparam logic [2:0] REG_BUF0   = 3'd0;
  localparam logic [2:0] REG_BUF1   = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_FRONT  = 3'd4;
  localparam logic [2:0] REG_BACK   = 3'd5;

  localparam int CTRL_SWAP_REQ  = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STAT_FRONT_IDX = 0;
  localparam int STAT_PENDING   = 1;
  localparam int STAT_IRQ_FLAG  = 2;
  localparam int STAT_FCNT_LSB  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLIP  = 2'd2
  } flip_state_e;

endpackage

// File: rtl/framebuffer_flip_ctrl_vsync.sv
// fb_vsync_edge_detect: brings the asynchronous vsync into clk via two
// flops and emits a one-cycle pulse on its synchronized rising edge.
// Ports: clk, reset_n (sync, active-low), i_vsync (async), o_rise.
module fb_vsync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_vsync,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_vsync;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s3 is the previous synchronized level, so a held-high
  // vsync yields exactly one pulse.
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/framebuffer_flip_ctrl.sv
// Avalon-MM double-buffer controller: flips the scan-out base on vsync.
// Ports: clk, reset_n, Avalon slave (address/chipselect/write_n/
// writedata/readdata), vsync_in, out_port (front base), irq.
module framebuffer_flip_ctrl
  import framebuffer_flip_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BUF0_RESET = 24'h000000,
  parameter logic [ADDR_W-1:0] BUF1_RESET = 24'h04B000,
  parameter int                FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] out_port,
  output logic              irq
);

  logic [ADDR_W-1:0] r_buf0;
  logic [ADDR_W-1:0] r_buf1;
  logic [ADDR_W-1:0] r_out;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_irq_en;
  logic              r_irq_flag;
  logic              r_front_idx;
  logic              r_pending;
  flip_state_e       r_state;
  flip_state_e       w_state_nxt;

  logic              w_vs_edge;
  logic              w_wr;
  logic              w_swap_wr;
  logic              w_w1c;
  logic              w_arm;
  logic              w_flip_now;
  logic              w_commit;
  logic              w_reload_idx;
  logic [ADDR_W-1:0] w_reload_addr;
  logic              w_unused;

  fb_vsync_edge_detect u_vs (
    .clk     (clk),
    .reset_n (reset_n),
    .i_vsync (vsync_in),
    .o_rise  (w_vs_edge)
  );

  assign w_wr = chipselect & ~write_n;

  assign w_swap_wr = w_wr
    && (address == REG_CTRL)
    && writedata[CTRL_SWAP_REQ];

  assign w_w1c = w_wr
    && (address == REG_STATUS)
    && writedata[STAT_IRQ_FLAG];

  assign w_unused = &{1'b0, writedata[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_flip_now  = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_swap_wr) begin
          w_state_nxt = ARMED;
          w_arm       = 1'b1;
        end
      end
      ARMED: begin
        if (w_vs_edge) begin
          w_state_nxt = FLIP;
          w_flip_now  = 1'b1;
        end
      end
      FLIP: begin
        w_state_nxt = IDLE;
        w_commit    = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The reload must see the post-flip index both on the edge that
  // arms the flip and during FLIP, before the toggle has landed.
  assign w_reload_idx  = r_front_idx ^ (w_flip_now | w_commit);
  assign w_reload_addr = w_reload_idx ? r_buf1 : r_buf0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_buf0      <= BUF0_RESET;
      r_buf1      <= BUF1_RESET;
      r_out       <= BUF0_RESET;
      r_fcnt      <= '0;
      r_irq_en    <= 1'b0;
      r_irq_flag  <= 1'b0;
      r_front_idx <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (w_wr && address == REG_BUF0) begin
        r_buf0 <= writedata[ADDR_W-1:0];
      end
      if (w_wr && address == REG_BUF1) begin
        r_buf1 <= writedata[ADDR_W-1:0];
      end
      if (w_wr && address == REG_CTRL) begin
        r_irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (w_arm) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_commit) begin
        r_front_idx <= ~r_front_idx;
      end
      // A flip landing with a clear request keeps the flag set.
      if (w_commit) begin
        r_irq_flag <= 1'b1;
      end else if (w_w1c) begin
        r_irq_flag <= 1'b0;
      end
      if (w_vs_edge) begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
        r_out  <= w_reload_addr;
      end
    end
  end

  assign out_port = r_out;
  assign irq      = r_irq_flag & r_irq_en;

  always_comb begin
    readdata = '0;
    case (address)
      REG_BUF0: begin
        readdata[ADDR_W-1:0] = r_buf0;
      end
      REG_BUF1: begin
        readdata[ADDR_W-1:0] = r_buf1;
      end
      REG_CTRL: begin
        readdata[CTRL_IRQ_EN] = r_irq_en;
      end
      REG_STATUS: begin
        readdata[STAT_FRONT_IDX] = r_front_idx;
        readdata[STAT_PENDING]   = r_pending;
        readdata[STAT_IRQ_FLAG]  = r_irq_flag;
        readdata[STAT_FCNT_LSB +: FCNT_W] = r_fcnt;
      end
      REG_FRONT: begin
        readdata[ADDR_W-1:0] = r_out;
      end
      REG_BACK: begin
        readdata[ADDR_W-1:0] = r_front_idx ? r_buf0 : r_buf1;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_framebuffer_flip_ctrl.sv
// Self-checking bench for framebuffer_flip_ctrl: directed scenarios plus
// randomized register/vsync traffic against a transaction-level model.
module tb_framebuffer_flip_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        vsync_in;
  logic [23:0] out_port;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [23:0] m_buf [2];
  bit          m_front;
  bit          m_pend;
  bit          m_flag;
  bit          m_en;
  logic [15:0] m_fcnt;
  logic [23:0] m_out;

  always #5 clk = ~clk;

  framebuffer_flip_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .vsync_in   (vsync_in),
    .out_port   (out_port),
    .irq        (irq)
  );

  function automatic void m_reset();
    m_buf[0] = 24'h000000;
    m_buf[1] = 24'h04B000;
    m_front  = 1'b0;
    m_pend   = 1'b0;
    m_flag   = 1'b0;
    m_en     = 1'b0;
    m_fcnt   = '0;
    m_out    = 24'h000000;
  endfunction

  // One vsync rising edge: pending flip lands, counter ticks,
  // scan-out base follows the (new) front buffer.
  function automatic void m_vsync();
    if (m_pend) begin
      m_front = ~m_front;
      m_pend  = 1'b0;
      m_flag  = 1'b1;
    end
    m_fcnt = m_fcnt + 16'd1;
    m_out  = m_buf[m_front];
  endfunction

  function automatic logic [31:0] m_reg(input int a);
    logic [31:0] v;
    v = '0;
    case (a)
      0: v[23:0] = m_buf[0];
      1: v[23:0] = m_buf[1];
      2: v[1] = m_en;
      3: v = {m_fcnt, 13'b0, m_flag, m_pend, m_front};
      4: v[23:0] = m_out;
      5: v[23:0] = m_buf[~m_front];
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic vsync_pulse(input int hold);
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (hold) @(negedge clk);
    vsync_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    checks++;
    if (out_port !== 24'h000000) begin
      failures++;
      $display("FAIL reset_out_port got=%h exp=000000", out_port);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_status got=%h exp=0", d);
    end
    bus_read(3'd1, d);
    checks++;
    if (d !== 32'h0004B000) begin
      failures++;
      $display("FAIL reset_buf1 got=%h exp=0004b000", d);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      checks++;
      if (d !== m_reg(a)) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=%h", a, d, m_reg(a));
      end
    end
  endtask

  task automatic test_flip();
    logic [31:0] d;
    logic [23:0] old;
    bus_write(3'd1, 32'h00123456);
    m_buf[1] = 24'h123456;
    bus_write(3'd2, 32'h1);
    m_pend = 1'b1;
    bus_read(3'd3, d);
    checks++;
    if (d[1:0] !== 2'b10) begin
      failures++;
      $display("FAIL flip_pending got=%b exp=10", d[1:0]);
    end
    old = m_out;
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_port !== old) begin
      failures++;
      $display("FAIL flip_early got=%h exp=%h", out_port, old);
    end
    @(negedge clk);
    m_vsync();
    checks++;
    if (out_port !== 24'h123456) begin
      failures++;
      $display("FAIL flip_edge3 got=%h exp=123456", out_port);
    end
    vsync_in = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h00010005) begin
      failures++;
      $display("FAIL flip_status got=%h exp=00010005", d);
    end
    bus_read(3'd4, d);
    checks++;
    if (d !== 32'h00123456) begin
      failures++;
      $display("FAIL flip_front got=%h exp=00123456", d);
    end
    bus_read(3'd5, d);
    checks++;
    if (d !== m_reg(5)) begin
      failures++;
      $display("FAIL flip_back got=%h exp=%h", d, m_reg(5));
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(3'd2, 32'h2);
    m_en = 1'b1;
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_enable got=%b exp=1", irq);
    end
    bus_write(3'd3, 32'h4);
    m_flag = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_w1c got=%b exp=0", irq);
    end
    bus_write(3'd2, 32'h3);
    m_pend = 1'b1;
    vsync_pulse(2);
    m_vsync();
    checks++;
    if (irq !== 1'b1 || out_port !== m_out) begin
      failures++;
      $display("FAIL irq_flip got=%b/%h exp=1/%h", irq, out_port, m_out);
    end
    bus_write(3'd3, 32'h4);
    m_flag = 1'b0;
    bus_write(3'd2, 32'h3);
    m_pend = 1'b1;
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    address    = 3'd3;
    writedata  = 32'h4;
    chipselect = 1'b1;
    write_n    = 1'b0;
    vsync_in   = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    m_vsync();
    repeat (3) @(negedge clk);
    bus_read(3'd3, d);
    checks++;
    if (d !== m_reg(3) || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set_wins got=%h/%b exp=%h/1", d, irq, m_reg(3));
    end
  endtask

  task automatic test_swap_on_edge();
    logic [31:0] d;
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    address    = 3'd2;
    writedata  = 32'h3;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    vsync_in   = 1'b0;
    m_vsync();
    m_pend = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(3'd3, d);
    checks++;
    if (d !== m_reg(3) || out_port !== m_out) begin
      failures++;
      $display("FAIL swap_edge_armed got=%h/%h exp=%h/%h",
               d, out_port, m_reg(3), m_out);
    end
    vsync_pulse(1);
    m_vsync();
    bus_read(3'd3, d);
    checks++;
    if (d !== m_reg(3) || out_port !== m_out) begin
      failures++;
      $display("FAIL swap_edge_flip got=%h/%h exp=%h/%h",
               d, out_port, m_reg(3), m_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit f0;
    f0 = m_front;
    bus_write(3'd2, 32'h3);
    bus_write(3'd2, 32'h3);
    m_pend = 1'b1;
    vsync_pulse(3);
    m_vsync();
    bus_read(3'd3, d);
    checks++;
    if (d !== m_reg(3) || d[0] === f0) begin
      failures++;
      $display("FAIL double_swap_one got=%h exp=%h", d, m_reg(3));
    end
    vsync_pulse(1);
    m_vsync();
    bus_read(3'd3, d);
    checks++;
    if (d !== m_reg(3) || d[0] === f0) begin
      failures++;
      $display("FAIL double_swap_none got=%h exp=%h", d, m_reg(3));
    end
  endtask

  task automatic test_front_write();
    logic [31:0] d;
    logic [23:0] old;
    if (m_front) begin
      bus_write(3'd2, 32'h3);
      m_pend = 1'b1;
      vsync_pulse(1);
      m_vsync();
    end
    old = m_out;
    bus_write(3'd0, 32'h000AAAAA);
    m_buf[0] = 24'h0AAAAA;
    repeat (4) @(negedge clk);
    checks++;
    if (out_port !== old) begin
      failures++;
      $display("FAIL front_wr_hold got=%h exp=%h", out_port, old);
    end
    vsync_pulse(2);
    m_vsync();
    bus_read(3'd3, d);
    checks++;
    if (out_port !== 24'h0AAAAA || d[0] !== 1'b0) begin
      failures++;
      $display("FAIL front_wr_apply got=%h/%b exp=0aaaaa/0",
               out_port, d[0]);
    end
    old = m_out;
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (2) @(negedge clk);
    address    = 3'd0;
    writedata  = 32'h00055555;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    vsync_in   = 1'b0;
    m_vsync();
    m_buf[0] = 24'h055555;
    checks++;
    if (out_port !== old) begin
      failures++;
      $display("FAIL buf_wr_on_edge got=%h exp=%h", out_port, old);
    end
    repeat (4) @(negedge clk);
    vsync_pulse(1);
    m_vsync();
    checks++;
    if (out_port !== 24'h055555) begin
      failures++;
      $display("FAIL buf_wr_next_edge got=%h exp=055555", out_port);
    end
  endtask

  task automatic test_reset_mid_armed();
    logic [31:0] d;
    bus_write(3'd2, 32'h1);
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    vsync_in = 1'b0;
    m_reset();
    repeat (5) @(negedge clk);
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h0 || out_port !== 24'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rst_armed got=%h/%h/%b exp=0/0/0",
               d, out_port, irq);
    end
    vsync_pulse(1);
    m_vsync();
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h00010000 || out_port !== 24'h0) begin
      failures++;
      $display("FAIL rst_no_flip got=%h/%h exp=00010000/0",
               d, out_port);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] r;
    int op;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      r  = $urandom;
      case (op)
        0: begin
          bus_write(3'd0, r);
          m_buf[0] = r[23:0];
        end
        1: begin
          bus_write(3'd1, r);
          m_buf[1] = r[23:0];
        end
        2: begin
          bus_write(3'd2, r);
          m_en = r[1];
          if (r[0]) m_pend = 1'b1;
        end
        3: begin
          bus_write(3'd3, r);
          if (r[2]) m_flag = 1'b0;
        end
        4: begin
          vsync_pulse($urandom_range(1, 6));
          m_vsync();
        end
        default: begin
          bus_write(3'($urandom_range(4, 7)), r);
        end
      endcase
      checks++;
      if (out_port !== m_out || irq !== (m_flag & m_en)) begin
        failures++;
        $display("FAIL rand%0d_out got=%h/%b exp=%h/%b",
                 it, out_port, irq, m_out, m_flag & m_en);
      end
      for (int a = 0; a < 8; a++) begin
        bus_read(3'(a), d);
        checks++;
        if (d !== m_reg(a)) begin
          failures++;
          $display("FAIL rand%0d_reg%0d got=%h exp=%h",
                   it, a, d, m_reg(a));
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    vsync_in   = 1'b0;
    m_reset();
    test_reset();
    test_flip();
    test_irq();
    test_swap_on_edge();
    test_back_to_back();
    test_front_write();
    test_reset_mid_armed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_flip_ctrl.md
Name: framebuffer_flip_ctrl

Overview:
- Avalon-MM slave that double-buffers the video framebuffer base address.
- CPU programs two 24-bit buffer bases and requests a page flip.
- The block applies the flip only at the next vertical-sync rising edge, so the scan-out DMA never tears.
- Drives the 24-bit front-buffer base to the video reader, keeps a frame counter and raises a flip-done interrupt.

Parameters:
- ADDR_W, 24, width of buffer base addresses and out_port.
- BUF0_RESET, 24'h000000, reset value of BUF0.
- BUF1_RESET, 24'h04B000, reset value of BUF1.
- FCNT_W, 16, frame counter width (must be ≤ 16).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  3  register word index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux of the addressed register; unused bits 0.
- vsync_in  in  1  vertical sync from the video timing block, asynchronous to clk, active-high.
- out_port  out  ADDR_W  current front-buffer base to the scan-out DMA.
- irq  out  1  level interrupt, equal to IRQ_FLAG & IRQ_EN.

Behaviour:
- Register map (word index):
  - 0 BUF0: RW, [23:0].
  - 1 BUF1: RW, [23:0].
  - 2 CTRL: bit0 SWAP_REQ (write-1 strobe, reads 0); bit1 IRQ_EN (RW).
  - 3 STATUS: bit0 FRONT_IDX (RO); bit1 PENDING (RO); bit2 IRQ_FLAG (write-1-to-clear); [31:16] FRAME_CNT (RO).
  - 4 FRONT_ADDR: RO, equals out_port.
  - 5 BACK_ADDR: RO, the BUF register not selected by FRONT_IDX.
  - 6–7: read 0, writes ignored.
- A write occurs when chipselect && !write_n. Register writes take effect on the next clk edge.
- Reset (reset_n low at a clk edge) sets:
  - BUF0=BUF0_RESET, BUF1=BUF1_RESET, IRQ_EN=0, FRONT_IDX=0.
  - PENDING=0, IRQ_FLAG=0, FRAME_CNT=0.
  - out_port=BUF0_RESET, irq=0, synchronizer flops=0, state=IDLE.
- vsync edge detect: vsync_in passes through flops s1→s2, then s3 holds the previous s2. vs_edge = s2 & ~s3.
  - out_port and FRAME_CNT update on the 3rd rising clk edge at which vsync_in is sampled high.
- FSM:
  - IDLE: a SWAP_REQ write → ARMED, PENDING=1.
  - ARMED: vs_edge → FLIP.
  - FLIP (one cycle): FRONT_IDX toggles, PENDING=0, IRQ_FLAG=1 → IDLE.
- On every vs_edge, independent of state:
  - FRAME_CNT increments, wrapping from all-ones to 0.
  - out_port reloads from BUF[FRONT_IDX'], using the post-flip index when this edge triggers a flip.
  - A write to the front buffer's BUF register therefore reaches out_port at the next vsync edge, not immediately.
- Flip timing: the vs_edge cycle sets the state to FLIP and out_port to BUF[~FRONT_IDX] at the same edge. The FLIP cycle then commits the FRONT_IDX toggle, so FRONT_ADDR is consistent from the cycle after.
- Boundary cases:
  - SWAP_REQ while ARMED or FLIP: ignored. At most one flip per vsync, no queued second flip.
  - SWAP_REQ in the same cycle as vs_edge in IDLE: → ARMED, and the flip waits for the following vsync edge.
  - Simultaneous W1C of IRQ_FLAG and its FLIP set: the set wins.
  - BUF write in the vs_edge cycle: out_port loads the old value, and the new value applies at the next edge.
  - reset_n low mid-ARMED or mid-FLIP: immediate return to reset state. The pending flip is discarded and out_port=BUF0_RESET.
  - vsync_in held high: exactly one edge is counted.

Decomposition:
- Package framebuffer_flip_pkg holds:
  - register index constants REG_BUF0..REG_BACK;
  - bit positions for SWAP_REQ, IRQ_EN, FRONT_IDX, PENDING, IRQ_FLAG;
  - the FSM state enum {IDLE, ARMED, FLIP}.
- One sub-module, fb_vsync_edge_detect: 3-flop synchronizer plus rising-edge pulse, with clk and reset_n.

Test Plan:
- Reset → out_port=0x000000, readdata@3=0, irq=0. Read BUF1 → 0x04B000.
- Write BUF1=0x123456, write CTRL=0x1 → STATUS.PENDING=1. Pulse vsync_in → out_port=0x123456 three edges after sampling, FRONT_IDX=1, PENDING=0, IRQ_FLAG=1, FRAME_CNT=1.
- Set IRQ_EN=1, then flip → irq=1. Write STATUS=0x4 → irq=0. Assert W1C in the FLIP cycle → IRQ_FLAG stays 1.
- Two SWAP_REQ writes before one vsync → exactly one FRONT_IDX toggle; a second vsync gives no further toggle.
- With FRONT_IDX=0, write BUF0=0x0AAAAA → out_port unchanged until the next vsync, then 0x0AAAAA with no flip and FRONT_IDX=0.
- SWAP_REQ, then reset_n low one cycle before vs_edge → after reset, out_port=0x000000, PENDING=0, and a following vsync causes no flip.
